seg_disp_arbiter: RTL

SEG_DISP_ARBITER -- requirements
Module: seg_disp_arbiter

---
 rtl/seg_disp_arbiter_pkg.sv | 6 +
 rtl/seg_disp_arbiter_if.sv | 12 +
 rtl/seg_disp_arbiter_rr_pick.sv | 23 ++
 rtl/seg_disp_arbiter.sv | 63 ++++++
 4 files changed

// File: rtl/seg_disp_arbiter_pkg.sv
// seg_disp_arbiter_pkg: shared state encoding, default dwell and counter width
package seg_disp_arbiter_pkg;
  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_e;
  localparam int SEGARB_HOLD_CYCLES = 100_000_000;
  localparam int CNT_W = 27;
endpackage

// File: rtl/seg_disp_arbiter_if.sv
// seg_disp_arbiter_if: requester-side and display-side signals of the arbiter
interface seg_disp_arbiter_if #(parameter int N_REQ = 4);
  logic [N_REQ-1:0]    REQ_VALID;
  logic [32*N_REQ-1:0] REQ_DATA;
  logic [N_REQ-1:0]    ACK;
  logic [31:0]         DISP_DATA;
  logic [2:0]          DISP_SRC;
  logic                DISP_VALID;
  logic                BUSY;
  modport master (output REQ_VALID, REQ_DATA, input ACK, DISP_DATA, DISP_SRC, DISP_VALID, BUSY);
  modport slave  (input REQ_VALID, REQ_DATA, output ACK, DISP_DATA, DISP_SRC, DISP_VALID, BUSY);
endinterface

// File: rtl/seg_disp_arbiter_rr_pick.sv
// rr_pick: round-robin winner search starting after last, last itself searched last
module rr_pick #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] req_valid_i,
  input  logic [2:0]       last_i,
  output logic [2:0]       winner_o,
  output logic             any_o
);
  logic [7:0] v;
  logic [2:0] idx;
  // walk the offsets from farthest to nearest so the nearest valid one wins
  always_comb begin
    v = 8'(req_valid_i);
    idx = '0;
    winner_o = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = 3'((int'(last_i) + k) % N_REQ);
      if (v[idx]) winner_o = idx;
    end
  end
  assign any_o = |req_valid_i;
endmodule

// File: rtl/seg_disp_arbiter.sv
// seg_disp_arbiter: round-robin capture of requester values onto a 7-segment display with a minimum dwell
module seg_disp_arbiter
  import seg_disp_arbiter_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int HOLD_CYCLES = SEGARB_HOLD_CYCLES
) (
  input logic CLK,
  input logic RST,
  seg_disp_arbiter_if.slave bus
);
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       last_q, last_d, src_q, src_d, winner;
  logic [31:0]      data_q, data_d, sel_data;
  logic             valid_q, valid_d, any, cap, expired;
  logic [N_REQ-1:0] ack_q, ack_d;
  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req_valid_i(bus.REQ_VALID),
    .last_i     (last_q),
    .winner_o   (winner),
    .any_o      (any)
  );
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N_REQ; i++) if (winner == 3'(i)) sel_data = bus.REQ_DATA[32*i +: 32];
  end
  assign expired = state_q == HOLD && cnt_q == CNT_W'(HOLD_CYCLES - 1);
  assign cap = any && (state_q == IDLE || expired);
  always_comb begin
    state_d = cap ? HOLD : expired ? IDLE : state_q;
    cnt_d   = (cap || expired) ? '0 : state_q == HOLD ? cnt_q + CNT_W'(1) : cnt_q;
    last_d  = cap ? winner : last_q;
    src_d   = cap ? winner : src_q;
    data_d  = cap ? sel_data : data_q;
    valid_d = cap | valid_q;
    ack_d   = cap ? N_REQ'(1) << winner : '0;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 3'(N_REQ - 1);
      src_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      src_q   <= src_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ack_q   <= ack_d;
    end
  end
  assign bus.ACK        = ack_q;
  assign bus.DISP_DATA  = data_q;
  assign bus.DISP_SRC   = src_q;
  assign bus.DISP_VALID = valid_q;
  assign bus.BUSY       = state_q == HOLD;
endmodule
